bcd_display_scan: RTL

BCD_DISPLAY_SCAN -- requirements
Module: bcd_display_scan

---
 rtl/bcd_display_scan.sv | 109 ++++++++++
 1 files changed

// File: rtl/bcd_display_scan.sv
// Four-digit multiplexed BCD display driver: frame-synchronous double buffer,
// leading-zero blanking and registered active-low segment/anode outputs.
module bcd_display_scan #(
  parameter int REFRESH_DIV = 50000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [15:0] bcd_in,
  input  logic        load,
  input  logic        blank_lz,
  output logic [6:0]  seg_n,
  output logic [3:0]  an_n,
  output logic        frame_done
);

  localparam int              CW       = $clog2(REFRESH_DIV);
  localparam logic [CW-1:0]   DIV_LAST = CW'(REFRESH_DIV - 1);

  logic [CW-1:0] presc_q, presc_d;
  logic [1:0]    idx_q, idx_d;
  logic [15:0]   shadow_q, shadow_d;
  logic [15:0]   display_q, display_d;
  logic          pending_q, pending_d;
  logic [6:0]    seg_q, seg_d;
  logic [3:0]    an_q, an_d;
  logic          frame_done_q;

  logic          tick;
  logic          boundary;
  logic [3:0]    nibble;
  logic [3:0]    lead_zero;
  logic          blank_digit;

  function automatic logic [6:0] seg_decode(input logic [3:0] n);
    case (n)
      4'd0:    seg_decode = 7'h40;
      4'd1:    seg_decode = 7'h79;
      4'd2:    seg_decode = 7'h24;
      4'd3:    seg_decode = 7'h30;
      4'd4:    seg_decode = 7'h19;
      4'd5:    seg_decode = 7'h12;
      4'd6:    seg_decode = 7'h02;
      4'd7:    seg_decode = 7'h78;
      4'd8:    seg_decode = 7'h00;
      4'd9:    seg_decode = 7'h10;
      default: seg_decode = 7'h3F;  // non-BCD nibble shows a dash
    endcase
  endfunction

  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
    tick      = (presc_q == DIV_LAST);
    boundary  = tick && (idx_q == 2'd3);
    presc_d   = tick ? '0 : presc_q + 1'b1;
    idx_d     = tick ? idx_q + 2'd1 : idx_q;
    shadow_d  = shadow_q;
    display_d = display_q;
    pending_d = pending_q;

    // A load on the boundary bypasses the shadow so it is not lost for a frame.
    if (load) begin
      shadow_d  = bcd_in;
      pending_d = !boundary;
      if (boundary) display_d = bcd_in;
    end else if (boundary && pending_q) begin
      display_d = shadow_q;
      pending_d = 1'b0;
    end

    // lead_zero[k]: display nibbles k..3 are all zero; digit 0 is never blanked.
    lead_zero[3] = (display_q[15:12] == 4'd0);
    lead_zero[2] = lead_zero[3] && (display_q[11:8] == 4'd0);
    lead_zero[1] = lead_zero[2] && (display_q[7:4] == 4'd0);
    lead_zero[0] = 1'b0;

    nibble      = display_q[{idx_q, 2'b00} +: 4];
    blank_digit = blank_lz && lead_zero[idx_q];
    seg_d       = blank_digit ? 7'h7F : seg_decode(nibble);
    an_d        = blank_digit ? 4'hF  : ~(4'b0001 << idx_q);
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      presc_q      <= '0;
      idx_q        <= 2'd0;
      shadow_q     <= 16'h0000;
      display_q    <= 16'h0000;
      pending_q    <= 1'b0;
      seg_q        <= 7'h7F;
      an_q         <= 4'hF;
      frame_done_q <= 1'b0;
    end else begin
      presc_q      <= presc_d;
      idx_q        <= idx_d;
      shadow_q     <= shadow_d;
      display_q    <= display_d;
      pending_q    <= pending_d;
      seg_q        <= seg_d;
      an_q         <= an_d;
      frame_done_q <= boundary;
    end
  end

  assign seg_n      = seg_q;
  assign an_n       = an_q;
  assign frame_done = frame_done_q;

endmodule
